pc_sequencer: RTL
=================

# pc_sequencer

Control sequencer for the 8-bit program counter. It turns decoded instruction ops, stall and a zero flag into the PC's `load`, `up_down` and `data` controls, and keeps a small hardware call/return stack. The PC has no hold mode: it always increments, decrements or loads. The sequencer holds the PC by reloading the PC's own `count`, fed back on `pc_count`. It sits between the instruction decoder and the PC in the CPU top level.

## Interface
- `AW`, 8, address/PC width
- `STACK_DEPTH`, 4, call-stack entries (power of two, ≥2)
- `RESET_VEC`, 8'h00, PC value forced while idle
- `clk` input 1: single clock, rising edge
- `reset_n` input 1: asynchronous, active-low reset
- `start` input 1: leave IDLE/HALT and begin execution
- `stall` input 1: freeze PC this cycle
- `op_valid` input 1: `op` and `op_target` valid this cycle
- `op` input 3: 0 NOP, 1 JMP, 2 JZ, 3 CALL, 4 RET, 5 BACK, 6 HALT, 7 reserved (= NOP)
- `op_target` input AW: jump/call destination
- `zero_flag` input 1: ALU zero, sampled for JZ
- `pc_count` input AW: current PC value, fed back from the PC
- `pc_load` output 1: to PC `load`
- `pc_up_down` output 1: to PC `up_down` (1 = +1, 0 = −1)
- `pc_data` output AW: to PC `data`
- `busy` output 1: state == RUN
- `halted` output 1: state == HALT
- `stack_err` output 1: sticky overflow/underflow flag

## Operation
- State: `IDLE`, `RUN`, `HALT` (registered), stack array, stack pointer `sp` (0..STACK_DEPTH), `stack_err`.
- Control outputs are combinational from registered state plus current inputs. The PC acts on them at the next rising edge.
- "Hold" means `pc_load`=1, `pc_data`=`pc_count`, `pc_up_down`=1.
- `IDLE`: `pc_load`=1, `pc_data`=RESET_VEC. On `start`, go to RUN.
- `HALT`: hold. On `start`, go to RUN. `stack_err` is unchanged.
- `RUN` with `stall`=1 or `op_valid`=0: hold. No stack or state change. `stall` has priority over any op.
- `RUN`, valid op, no stall:
  - NOP/reserved: `pc_load`=0, `pc_up_down`=1.
  - BACK: `pc_load`=0, `pc_up_down`=0.
  - JMP: load `op_target`.
  - JZ: if `zero_flag`, load `op_target`; otherwise behave as NOP.
  - CALL, `sp`<STACK_DEPTH: push (`pc_count`+1) mod 2^AW, `sp`++, load `op_target`.
  - CALL, stack full: no push, hold, set `stack_err`, go to HALT.
  - RET, `sp`>0: `sp`--, load the popped entry.
  - RET, stack empty: hold, set `stack_err`, go to HALT.
  - HALT: hold, go to HALT.
- `start` is ignored in RUN.
- Arithmetic is modulo 2^AW:
  - NOP at 8'hFF yields 8'h00.
  - BACK at 8'h00 yields 8'hFF.
  - CALL at 8'hFF pushes 8'h00.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, `sp`=0, `stack_err`=0, stack entries=0.
  - Outputs during reset: `pc_load`=1, `pc_data`=RESET_VEC, `pc_up_down`=1, `busy`=0, `halted`=0.
- Reset asserted mid-RUN empties the stack immediately. Outputs reflect IDLE in the same cycle.
- Op latency: an op presented in cycle N updates `pc_count` at edge N+1. Push/pop and state changes commit at the same edge.
- `start` sampled at edge N: `busy`=1 from N+1. The first op is accepted in cycle N+1.
- `stack_err` rises at the edge that commits the faulting CALL/RET and stays set until reset.
- Back-to-back CALL/RET in consecutive cycles is supported with no bubble. RET directly after CALL returns to CALL address+1.

## Structure
- Shared CPU package holds:
  - op encodings (`OP_NOP`…`OP_HALT`),
  - state encoding,
  - `AW`/`RESET_VEC` defaults.
- One natural sub-module: `pc_call_stack`, a LIFO with push/pop/full/empty and a registered `sp`, parameterised by AW and STACK_DEPTH.

## Test plan
- Reset, then `start`, then 3 NOPs from RESET_VEC=0 → `pc_count` 0,1,2,3. Then BACK → 2.
- JMP 8'h40 → 8'h40. JZ 8'h10 with `zero_flag`=0 → 8'h41. JZ 8'h10 with `zero_flag`=1 → 8'h10.
- At 8'h20, CALL 8'h80, then NOP, then RET → 8'h80, 8'h81, 8'h21. `sp` ends at 0.
- 4 nested CALLs, then a 5th → `stack_err`=1, `halted`=1, PC unchanged thereafter. A later `start` resumes RUN with `stack_err` still 1.
- RET on empty stack → `stack_err`=1, HALT. `stall`=1 with CALL presented → PC held, `sp` unchanged.
- At 8'hFF, NOP → 8'h00. Async `reset_n` low mid-CALL sequence → `sp`=0, IDLE, `pc_data`=RESET_VEC in the same cycle.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared CPU definitions for the PC control path.
// Holds the op encodings, the sequencer state encoding and the default widths and vectors.
package pc_sequencer_pkg;

  localparam int unsigned AW_DEF          = 8;
  localparam int unsigned STACK_DEPTH_DEF = 4;
  localparam logic [7:0]  RESET_VEC_DEF   = 8'h00;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_JMP  = 3'd1,
    OP_JZ   = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4,
    OP_BACK = 3'd5,
    OP_HALT = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

endpackage

// File: rtl/pc_call_stack.sv
// Hardware call/return LIFO with a registered stack pointer.
// A push into a full stack and a pop from an empty stack are both ignored.
module pc_call_stack #(
  parameter int unsigned AW          = 8,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top_data,
  output logic          full,
  output logic          empty
);

  localparam int unsigned IW  = $clog2(STACK_DEPTH);
  localparam int unsigned SPW = IW + 1;

  logic [AW-1:0]  mem_q [STACK_DEPTH];
  logic [SPW-1:0] sp_q;
  logic [SPW-1:0] sp_d;
  logic [IW-1:0]  top_idx;
  logic           do_push;
  logic           do_pop;

  assign full     = (sp_q == SPW'(STACK_DEPTH));
  assign empty    = (sp_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  // sp counts occupied entries, so the top entry sits one below it
  assign top_idx  = IW'(sp_q - SPW'(1));
  assign top_data = mem_q[top_idx];

  always_comb begin
    sp_d = sp_q;
    if (do_push) begin
      sp_d = sp_q + SPW'(1);
    end else if (do_pop) begin
      sp_d = sp_q - SPW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp_q <= '0;
      for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      sp_q <= sp_d;
      if (do_push) begin
        mem_q[sp_q[IW-1:0]] <= push_data;
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC control sequencer: turns decoded ops, stall and zero flag into PC load/up_down/data.
// The PC cannot hold, so holding is done by reloading its own count.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned    AW          = AW_DEF,
  parameter int unsigned    STACK_DEPTH = STACK_DEPTH_DEF,
  parameter logic [AW-1:0]  RESET_VEC   = AW'(RESET_VEC_DEF)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          stall,
  input  logic          op_valid,
  input  logic [2:0]    op,
  input  logic [AW-1:0] op_target,
  input  logic          zero_flag,
  input  logic [AW-1:0] pc_count,
  output logic          pc_load,
  output logic          pc_up_down,
  output logic [AW-1:0] pc_data,
  output logic          busy,
  output logic          halted,
  output logic          stack_err
);

  state_e        state_q;
  state_e        state_d;
  logic          stack_err_q;
  logic          err_set;
  logic          stk_push;
  logic          stk_pop;
  logic          stk_full;
  logic          stk_empty;
  logic [AW-1:0] stk_top;
  logic [AW-1:0] ret_addr;
  op_e           op_dec;

  assign op_dec   = op_e'(op);
  assign ret_addr = pc_count + AW'(1);

  pc_call_stack #(
    .AW          (AW),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (ret_addr),
    .top_data  (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  always_comb begin
    state_d    = state_q;
    pc_load    = 1'b1;
    pc_up_down = 1'b1;
    pc_data    = pc_count;
    stk_push   = 1'b0;
    stk_pop    = 1'b0;
    err_set    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        pc_data = RESET_VEC;
        if (start) state_d = ST_RUN;
      end
      ST_HALT: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        // stall or no valid op leaves the default hold in place
        if (op_valid && !stall) begin
          case (op_dec)
            OP_JMP: pc_data = op_target;
            OP_JZ: begin
              if (zero_flag) pc_data = op_target;
              else           pc_load = 1'b0;
            end
            OP_CALL: begin
              if (!stk_full) begin
                stk_push = 1'b1;
                pc_data  = op_target;
              end else begin
                err_set = 1'b1;
                state_d = ST_HALT;
              end
            end
            OP_RET: begin
              if (!stk_empty) begin
                stk_pop = 1'b1;
                pc_data = stk_top;
              end else begin
                err_set = 1'b1;
                state_d = ST_HALT;
              end
            end
            OP_BACK: begin
              pc_load    = 1'b0;
              pc_up_down = 1'b0;
            end
            OP_HALT: state_d = ST_HALT;
            default: pc_load = 1'b0;
          endcase
        end
      end
      default: begin
        pc_data = RESET_VEC;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      stack_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (err_set) stack_err_q <= 1'b1;
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign halted    = (state_q == ST_HALT);
  assign stack_err = stack_err_q;

endmodule
